// File: rtl/pipeline_pkg.sv
// Shared opcodes, control-group widths and field indices
// for the pipelined control path.
package pipeline_pkg;

  localparam int OP_RTYPE = 0;
  localparam int OP_LW    = 1;
  localparam int OP_SW    = 2;
  localparam int OP_BEQ   = 3;
  localparam int OP_JUMP  = 4;

  localparam int WB_W  = 2;
  localparam int MEM_W = 2;
  localparam int EX_W  = 4;

  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;
  localparam int MEM_MEMREAD  = 1;
  localparam int MEM_MEMWRITE = 0;

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [MEM_W-1:0] mem;
    logic [EX_W-1:0]  ex;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipelined_control_hazard.sv
// Combinational load-use hazard and branch/jump
// redirect detection for the ID stage.
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int REG_ADDR_W = 5,
  parameter bit HAZARD_EN  = 1'b1
) (
  input  logic [OPCODE_W-1:0]   i_op,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rt,
  input  logic                  i_reg_equal,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  output logic                  o_hazard,
  output logic                  o_redirect
);

  logic w_rt_nz;
  logic w_match;
  logic w_is_beq;
  logic w_is_jump;

  assign w_rt_nz = (i_ex_rt != '0);
  assign w_match = (i_ex_rt == i_rs) ||
                   (i_ex_rt == i_rt);

  assign o_hazard = HAZARD_EN &&
                    i_ex_mem_read &&
                    w_rt_nz &&
                    w_match;

  assign w_is_beq  = (i_op == OPCODE_W'(OP_BEQ));
  assign w_is_jump = (i_op == OPCODE_W'(OP_JUMP));

  assign o_redirect = (w_is_beq && i_reg_equal) ||
                      w_is_jump;

endmodule

// File: rtl/pipelined_control.sv
// Pipelined control: decode, ID/EX, EX/MEM, MEM/WB
// control registers, stall/flush priority, sticky illegal flag.
module pipelined_control
  import pipeline_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int REG_ADDR_W = 5,
  parameter bit HAZARD_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [OPCODE_W-1:0]   opCode,
  input  logic [REG_ADDR_W-1:0] rsId,
  input  logic [REG_ADDR_W-1:0] rtId,
  input  logic                  registerEqual,
  input  logic                  stallIn,
  output logic [WB_W-1:0]       idExWb,
  output logic [MEM_W-1:0]      idExMem,
  output logic [EX_W-1:0]       idExCalc,
  output logic [REG_ADDR_W-1:0] idExRt,
  output logic [WB_W-1:0]       exMemWb,
  output logic [MEM_W-1:0]      exMemMem,
  output logic [WB_W-1:0]       memWbWb,
  output logic                  pcWrite,
  output logic                  ifIdWrite,
  output logic                  ifIdFlush,
  output logic                  branch,
  output logic                  illegalOp
);

  ctrl_t                 r_idex;
  logic [REG_ADDR_W-1:0] r_idex_rt;
  logic [WB_W-1:0]       r_exmem_wb;
  logic [MEM_W-1:0]      r_exmem_mem;
  logic [WB_W-1:0]       r_memwb_wb;
  logic                  r_illegal;

  ctrl_t w_dec;
  logic  w_illegal;
  logic  w_is_rtype;
  logic  w_is_lw;
  logic  w_is_sw;
  logic  w_is_beq;
  logic  w_is_jump;
  logic  w_hazard;
  logic  w_redirect;
  logic  w_advance;

  assign w_is_rtype = (opCode == OPCODE_W'(OP_RTYPE));
  assign w_is_lw    = (opCode == OPCODE_W'(OP_LW));
  assign w_is_sw    = (opCode == OPCODE_W'(OP_SW));
  assign w_is_beq   = (opCode == OPCODE_W'(OP_BEQ));
  assign w_is_jump  = (opCode == OPCODE_W'(OP_JUMP));

  // Undefined opcodes decode to a bubble, never X.
  always_comb begin
    w_dec     = CTRL_BUBBLE;
    w_illegal = 1'b0;
    unique case (1'b1)
      w_is_rtype: w_dec = '{wb: 2'b10, mem: 2'b00,
                            ex: 4'b1100};
      w_is_lw:    w_dec = '{wb: 2'b11, mem: 2'b10,
                            ex: 4'b0001};
      w_is_sw:    w_dec = '{wb: 2'b00, mem: 2'b01,
                            ex: 4'b0001};
      w_is_beq:   w_dec = CTRL_BUBBLE;
      w_is_jump:  w_dec = CTRL_BUBBLE;
      default:    w_illegal = 1'b1;
    endcase
  end

  hazard_unit #(
    .OPCODE_W   (OPCODE_W),
    .REG_ADDR_W (REG_ADDR_W),
    .HAZARD_EN  (HAZARD_EN)
  ) u_hazard (
    .i_op          (opCode),
    .i_rs          (rsId),
    .i_rt          (rtId),
    .i_reg_equal   (registerEqual),
    .i_ex_mem_read (r_idex.mem[MEM_MEMREAD]),
    .i_ex_rt       (r_idex_rt),
    .o_hazard      (w_hazard),
    .o_redirect    (w_redirect)
  );

  assign w_advance = reset_n && !stallIn && !w_hazard;

  assign pcWrite   = w_advance;
  assign ifIdWrite = w_advance;
  assign branch    = w_advance && w_redirect;
  assign ifIdFlush = w_advance && w_redirect;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idex      <= CTRL_BUBBLE;
      r_idex_rt   <= '0;
      r_exmem_wb  <= '0;
      r_exmem_mem <= '0;
      r_memwb_wb  <= '0;
      r_illegal   <= 1'b0;
    end else if (!stallIn) begin
      r_exmem_wb  <= r_idex.wb;
      r_exmem_mem <= r_idex.mem;
      r_memwb_wb  <= r_exmem_wb;
      if (w_hazard) begin
        r_idex    <= CTRL_BUBBLE;
        r_idex_rt <= '0;
      end else begin
        r_idex    <= w_dec;
        r_idex_rt <= rtId;
        if (w_illegal) begin
          r_illegal <= 1'b1;
        end
      end
    end
  end

  assign idExWb    = r_idex.wb;
  assign idExMem   = r_idex.mem;
  assign idExCalc  = r_idex.ex;
  assign idExRt    = r_idex_rt;
  assign exMemWb   = r_exmem_wb;
  assign exMemMem  = r_exmem_mem;
  assign memWbWb   = r_memwb_wb;
  assign illegalOp = r_illegal;

endmodule
